// File: rtl/seq_detect_prog.sv
`default_nettype none
// seq_detect_prog: runtime-programmable serial bit-pattern detector with
// overlap/non-overlap matching, saturating match counter and prefix progress.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter int                 DEF_LEN     = 5,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b10101),
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [LW-1:0]      cfg_len,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic               overlap_en,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LW-1:0]      progress,
  output logic               cfg_err
);

  localparam logic [LW-1:0]      LEN_MAX = LW'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] ONES    = '1;

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      fill;
  logic [LW-1:0]      len;

  logic               cfg_ok;
  logic               accept;
  logic               hit;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;
  logic [LW-1:0]      fill_after;
  logic [LW-1:0]      prog_next;

  assign cfg_ok     = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_MAX);
  // A legal config load claims the cycle, so any din sampled with it is dropped.
  assign accept     = din_valid && !cfg_ok;
  assign hist_next  = {hist[MAX_LEN-2:0], din};
  assign fill_inc   = (fill == LEN_MAX) ? fill : fill + 1'b1;
  assign len_mask   = ONES >> (MAX_LEN - int'(len));
  assign hit        = (fill_inc >= len) && (((hist_next ^ pattern) & len_mask) == '0);
  assign fill_after = (hit && !overlap_en) ? '0 : fill_inc;

  // Longest proper prefix of the pattern that the newest history bits end with.
  always_comb begin
    prog_next = '0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((k < int'(len)) && (k <= int'(fill_after)) &&
          (((hist_next ^ (pattern >> (int'(len) - k))) & (ONES >> (MAX_LEN - k))) == '0))
        prog_next = LW'(k);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hist        <= '0;
      fill        <= '0;
      progress    <= '0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
      len         <= LW'(DEF_LEN);
      pattern     <= DEF_PATTERN;
    end else begin
      match   <= accept && hit;
      cfg_err <= cfg_we && !cfg_ok;

      if (cnt_clr)
        match_count <= (accept && hit) ? CNT_W'(1) : '0;
      else if (accept && hit && !(&match_count))
        match_count <= match_count + 1'b1;

      if (cfg_ok) begin
        len      <= cfg_len;
        pattern  <= cfg_pattern;
        fill     <= '0;
        progress <= '0;
      end else if (din_valid) begin
        hist     <= hist_next;
        fill     <= fill_after;
        progress <= prog_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the fixed five-bit sequence-detector FSM. The match pattern (up to MAX_LEN bits) and its length are loaded at run time, and overlapping or non-overlapping detection is selectable. It sits on a qualified serial bit stream and provides a registered match pulse, a match counter and a prefix-progress state output.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match-counter width.
- DEF_LEN, 5: pattern length after reset (1..MAX_LEN).
- DEF_PATTERN, 'b10101: pattern after reset, right-aligned, MAX_LEN bits.
- LW: derived, $clog2(MAX_LEN+1); not overridable.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  load cfg_len/cfg_pattern this cycle.
- cfg_len  in  LW  new pattern length.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned.
- overlap_en  in  1  1 = overlapping detection; 0 = non-overlapping. Sampled every cycle.
- din_valid  in  1  din qualifier.
- din  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_count.
- match  out  1  one-cycle registered match pulse.
- match_count  out  CNT_W  saturating match count.
- progress  out  LW  length of the longest matched pattern prefix.
- cfg_err  out  1  one-cycle pulse on rejected config.

## Operation
- Bit order:
  - pattern[len-1] is the first bit expected and pattern[0] is the last.
  - The history shift register takes the newest bit into bit 0: hist <= {hist[MAX_LEN-2:0], din}.
- fill counts the valid history bits and saturates at MAX_LEN.
- On a cycle with din_valid=1 and no accepted cfg_we:
  - shift hist and increment fill;
  - the match condition is evaluated on the post-shift history.
- Match condition: fill_next ≥ len and hist_next[len-1:0] == pattern[len-1:0]. Bits at or above len are ignored.
- On a match:
  - match=1 next cycle;
  - match_count increments, saturating at 2^CNT_W-1;
  - if overlap_en=0, fill is reset to 0, so history before the match cannot contribute to the next match.
- progress:
  - largest k in 0..len-1 with k ≤ fill_next and the newest k bits equal pattern[len-1:len-k];
  - evaluated after any non-overlap fill clear;
  - registered, and updated only on accepted din_valid cycles.
- Configuration:
  - cfg_we with 1 ≤ cfg_len ≤ MAX_LEN: latch len and pattern, set fill=0 and progress=0, and drop any din sampled that cycle. match_count is unaffected.
  - cfg_we with an illegal cfg_len (0 or >MAX_LEN): configuration unchanged, cfg_err=1 for one cycle. din is processed normally that cycle.
- cnt_clr and a match in the same cycle: match_count=1.
- cnt_clr alone: match_count=0.
- din_valid=0: all state is held; match=0.

## Timing
- Reset values (asynchronous on clr):
  - hist=0, fill=0, progress=0;
  - match=0, match_count=0, cfg_err=0;
  - len=DEF_LEN, pattern=DEF_PATTERN.
- Latency:
  - match asserts in the cycle after the edge that samples the final pattern bit, for exactly one cycle;
  - progress and match_count update on that same edge.
- Match rate: back-to-back matches are possible every cycle in overlap mode (e.g. len=1).
- A new configuration takes effect on the first din_valid cycle after the cfg_we edge.
- clr mid-sequence discards the partial match; any loaded configuration reverts to the defaults.

## Test plan
- Default config, overlap_en=1, stream 1,0,1,0,1,0,1 -> match pulses after bits 5 and 7; match_count=2; progress after bit 4 = 4.
- Default config, overlap_en=0, same stream -> single match after bit 5; then 0,1,0,1 gives no match until 1,0,1,0,1 is fed again; match_count=2.
- After stream 1,0,1 load cfg_len=3, cfg_pattern=3'b110; then stream 0,1,1,0 -> match only after the final 0; progress=0 right after cfg_we.
- cfg_we with cfg_len=0, then with cfg_len=9 (MAX_LEN=8) -> cfg_err pulses twice; pattern 10101 still matched.
- CNT_W=2, five matches -> match_count 1,2,3,3,3. Then cnt_clr coinciding with a match -> 1.
- Stream 1,0,1,0, then clr for one cycle, then 1 -> no match; progress=1; match_count=0.
